id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID/EX pipeline register for the RV32 five-stage pipeline; sits directly downstream of the opcode control decoder.
- Captures the decoder's control bundle together with operands, immediate, register indices and funct fields for the execute stage.
- Detects load-use hazards, inserts bubbles, and honours flush (taken branch) and downstream hold.
- Keeps a saturating bubble counter for performance debug.

Parameters:
- XLEN, 32, datapath width of PC, operands and immediate.
- CNT_W, 16, width of the bubble counter.

Ports:
- clk  in  1  pipeline clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  ID stage holds a real instruction.
- id_pc  in  XLEN  PC of the ID instruction.
- id_rs1_data, id_rs2_data  in  XLEN  register-file read data.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1, id_rs2, id_rd  in  5  register indices.
- id_funct3  in  3  funct3 field.
- id_funct7b5  in  1  instruction bit 30.
- id_branch, id_memRead, id_memToReg, id_memWrite, id_ALUSrc, id_regWrite  in  1  decoder controls.
- id_ALUOp  in  2  decoder ALU class.
- flush  in  1  taken-branch redirect from EX/MEM; kill the ID/EX contents.
- stall_in  in  1  downstream hold; keep the ID/EX contents.
- ex_valid  out  1  EX holds a real instruction.
- ex_pc, ex_rs1_data, ex_rs2_data, ex_imm  out  XLEN  registered copies of the ID fields.
- ex_rs1, ex_rs2, ex_rd  out  5  registered copies of the ID indices.
- ex_funct3  out  3  registered copy.
- ex_funct7b5  out  1  registered copy.
- ex_branch, ex_memRead, ex_memToReg, ex_memWrite, ex_ALUSrc, ex_regWrite  out  1  registered controls.
- ex_ALUOp  out  2  registered control.
- hazard_stall  out  1  combinational; freeze PC and IF/ID this cycle.
- bubble_count  out  CNT_W  number of bubbles inserted, saturating.

Behaviour:
- Reset: when rst is high at a rising edge, every ex_* output becomes 0, ex_valid becomes 0 and bubble_count becomes 0. Reset overrides all other inputs; reset mid-stall leaves no residual hold.
- Hazard detection (combinational):
  - hazard_stall = id_valid & ex_valid & ex_memRead & (ex_rd != 0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2)).
  - The rs2 comparison is made even for I-type instructions. This conservative extra stall is accepted.
  - hazard_stall is forced to 0 while flush is high.
- Per-edge priority when not in reset (highest first):
  1. flush: load a bubble. No count.
  2. stall_in: hold all ex_* outputs and ex_valid unchanged.
  3. hazard_stall: load a bubble and increment bubble_count.
  4. Otherwise load: ex_* take the corresponding id_* values; ex_valid takes id_valid.
- Bubble: ex_valid = 0; ex_branch, ex_memRead, ex_memToReg, ex_memWrite, ex_ALUSrc, ex_regWrite and ex_ALUOp = 0. Data and index fields are loaded from ID but carry no meaning; the bench must not check them while ex_valid = 0.
- id_valid = 0 on a normal load: the control outputs are still loaded verbatim. Consumers must gate their side effects with ex_valid.
- Latency: 1 cycle from ID to EX. A load-use pair costs exactly 1 bubble, because after the bubble the load has left EX and hazard_stall drops.
- hazard_stall may be high while stall_in is high. The upstream freeze is still correct, and no bubble is counted that cycle.
- bubble_count saturates at all ones and does not wrap.
- No X propagation: every register has a defined reset value.

Test Plan:
- Reset: rst high for 2 cycles with arbitrary ID inputs -> all outputs 0, hazard_stall 0, bubble_count 0.
- Pass-through: R-type with id_rd=5, rs1=1, rs2=2, rs1_data=0x10, rs2_data=0x20, ALUOp=2'b10, regWrite=1 -> one edge later ex_valid=1, ex_rd=5, ex_rs1_data=0x10, ex_ALUOp=2'b10, ex_regWrite=1.
- Load-use: lw x7 loaded into EX, then ID holds add with rs1=7 -> hazard_stall=1; next edge ex_valid=0, all controls 0, bubble_count=1. The following cycle hazard_stall=0 and the add loads with ex_rs1=7.
- x0 exemption: lw with ex_rd=0 followed by an ID instruction with rs1=0 -> hazard_stall stays 0, no bubble inserted.
- Flush vs stall: flush=1 and stall_in=1 together with a valid ID sw -> ex_valid=0, ex_memWrite=0, bubble_count unchanged. With stall_in=1 alone, ex_* hold for 3 cycles and resume on release.
- Saturation: CNT_W=2, force 5 load-use bubbles -> bubble_count goes 1, 2, 3, 3, 3.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register for the RV32 five-stage pipeline.
// Captures the decoder control bundle plus operands, immediate, register
// indices and funct fields. It also detects load-use hazards, inserts bubbles,
// honours flush and downstream hold, and counts inserted bubbles (saturating).
module id_ex_stage #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [XLEN-1:0]  id_pc,
  input  logic [XLEN-1:0]  id_rs1_data,
  input  logic [XLEN-1:0]  id_rs2_data,
  input  logic [XLEN-1:0]  id_imm,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic [4:0]       id_rd,
  input  logic [2:0]       id_funct3,
  input  logic             id_funct7b5,
  input  logic             id_branch,
  input  logic             id_memRead,
  input  logic             id_memToReg,
  input  logic             id_memWrite,
  input  logic             id_ALUSrc,
  input  logic             id_regWrite,
  input  logic [1:0]       id_ALUOp,
  input  logic             flush,
  input  logic             stall_in,
  output logic             ex_valid,
  output logic [XLEN-1:0]  ex_pc,
  output logic [XLEN-1:0]  ex_rs1_data,
  output logic [XLEN-1:0]  ex_rs2_data,
  output logic [XLEN-1:0]  ex_imm,
  output logic [4:0]       ex_rs1,
  output logic [4:0]       ex_rs2,
  output logic [4:0]       ex_rd,
  output logic [2:0]       ex_funct3,
  output logic             ex_funct7b5,
  output logic             ex_branch,
  output logic             ex_memRead,
  output logic             ex_memToReg,
  output logic             ex_memWrite,
  output logic             ex_ALUSrc,
  output logic             ex_regWrite,
  output logic [1:0]       ex_ALUOp,
  output logic             hazard_stall,
  output logic [CNT_W-1:0] bubble_count
);

  // A load in EX whose destination is a source of the ID instruction.
  // rs2 is compared even for I-type instructions; the occasional extra
  // stall is cheaper than decoding the format here.
  logic load_use;
  // Data/index fields move whenever the stage is not held; a flush
  // always moves them because the kill must take effect immediately.
  logic load_en;
  // The control bundle is cleared (bubble) on flush or load-use hazard.
  logic bubble;

  // Hazard detection and the per-edge load/bubble decisions.
  always_comb begin
    load_use     = ex_valid & ex_memRead & (ex_rd != 5'd0) &
                   ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    hazard_stall = id_valid & load_use & ~flush;
    load_en      = flush | ~stall_in;
    bubble       = flush | hazard_stall;
  end

  // Data and index fields: copied from ID on every non-held edge; their
  // content is meaningless while ex_valid is low.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_pc       <= '0;
      ex_rs1_data <= '0;
      ex_rs2_data <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_funct3   <= '0;
      ex_funct7b5 <= 1'b0;
    end else if (load_en) begin
      ex_pc       <= id_pc;
      ex_rs1_data <= id_rs1_data;
      ex_rs2_data <= id_rs2_data;
      ex_imm      <= id_imm;
      ex_rs1      <= id_rs1;
      ex_rs2      <= id_rs2;
      ex_rd       <= id_rd;
      ex_funct3   <= id_funct3;
      ex_funct7b5 <= id_funct7b5;
    end
  end

  // Valid bit and control bundle: bubble clears them, a normal load
  // copies them verbatim (even when id_valid is low).
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid    <= 1'b0;
      ex_branch   <= 1'b0;
      ex_memRead  <= 1'b0;
      ex_memToReg <= 1'b0;
      ex_memWrite <= 1'b0;
      ex_ALUSrc   <= 1'b0;
      ex_regWrite <= 1'b0;
      ex_ALUOp    <= 2'b00;
    end else if (load_en) begin
      if (bubble) begin
        ex_valid    <= 1'b0;
        ex_branch   <= 1'b0;
        ex_memRead  <= 1'b0;
        ex_memToReg <= 1'b0;
        ex_memWrite <= 1'b0;
        ex_ALUSrc   <= 1'b0;
        ex_regWrite <= 1'b0;
        ex_ALUOp    <= 2'b00;
      end else begin
        ex_valid    <= id_valid;
        ex_branch   <= id_branch;
        ex_memRead  <= id_memRead;
        ex_memToReg <= id_memToReg;
        ex_memWrite <= id_memWrite;
        ex_ALUSrc   <= id_ALUSrc;
        ex_regWrite <= id_regWrite;
        ex_ALUOp    <= id_ALUOp;
      end
    end
  end

  // Bubble counter: counts only hazard bubbles that actually enter EX
  // (not flushes, not hazards masked by a downstream hold); saturates.
  always_ff @(posedge clk) begin
    if (rst) begin
      bubble_count <= '0;
    end else if (hazard_stall && !stall_in && (bubble_count != {CNT_W{1'b1}})) begin
      bubble_count <= bubble_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: a rule-level model of the ID/EX
// contents is compared against two DUT instances (default counter width and
// a 2-bit counter) every cycle, plus directed literal checks.
module tb_id_ex_stage;

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic [31:0] r1d;
    logic [31:0] r2d;
    logic [31:0] imm;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic        f7;
    logic        br;
    logic        mr;
    logic        m2r;
    logic        mw;
    logic        as;
    logic        rw;
    logic [1:0]  op;
  } stage_t;

  logic clk = 1'b0;
  logic rst, flush, stall_in;
  stage_t id_in;

  logic        id_valid, id_funct7b5, id_branch, id_memRead, id_memToReg;
  logic        id_memWrite, id_ALUSrc, id_regWrite;
  logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
  logic [4:0]  id_rs1, id_rs2, id_rd;
  logic [2:0]  id_funct3;
  logic [1:0]  id_ALUOp;

  assign id_valid    = id_in.v;
  assign id_pc       = id_in.pc;
  assign id_rs1_data = id_in.r1d;
  assign id_rs2_data = id_in.r2d;
  assign id_imm      = id_in.imm;
  assign id_rs1      = id_in.rs1;
  assign id_rs2      = id_in.rs2;
  assign id_rd       = id_in.rd;
  assign id_funct3   = id_in.f3;
  assign id_funct7b5 = id_in.f7;
  assign id_branch   = id_in.br;
  assign id_memRead  = id_in.mr;
  assign id_memToReg = id_in.m2r;
  assign id_memWrite = id_in.mw;
  assign id_ALUSrc   = id_in.as;
  assign id_regWrite = id_in.rw;
  assign id_ALUOp    = id_in.op;

  // DUT 1 outputs
  logic        ex_valid, ex_funct7b5, ex_branch, ex_memRead, ex_memToReg;
  logic        ex_memWrite, ex_ALUSrc, ex_regWrite, hazard_stall;
  logic [31:0] ex_pc, ex_rs1_data, ex_rs2_data, ex_imm;
  logic [4:0]  ex_rs1, ex_rs2, ex_rd;
  logic [2:0]  ex_funct3;
  logic [1:0]  ex_ALUOp;
  logic [15:0] bubble_count;
  // DUT 2 outputs (2-bit counter)
  logic        d2_valid, d2_funct7b5, d2_branch, d2_memRead, d2_memToReg;
  logic        d2_memWrite, d2_ALUSrc, d2_regWrite, d2_hazard;
  logic [31:0] d2_pc, d2_rs1_data, d2_rs2_data, d2_imm;
  logic [4:0]  d2_rs1, d2_rs2, d2_rd;
  logic [2:0]  d2_funct3;
  logic [1:0]  d2_ALUOp;
  logic [1:0]  d2_count;

  stage_t dut_ex;
  assign dut_ex = {ex_valid, ex_pc, ex_rs1_data, ex_rs2_data, ex_imm, ex_rs1, ex_rs2,
                   ex_rd, ex_funct3, ex_funct7b5, ex_branch, ex_memRead, ex_memToReg,
                   ex_memWrite, ex_ALUSrc, ex_regWrite, ex_ALUOp};

  id_ex_stage #(.XLEN(32), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .id_branch(id_branch), .id_memRead(id_memRead),
    .id_memToReg(id_memToReg), .id_memWrite(id_memWrite), .id_ALUSrc(id_ALUSrc),
    .id_regWrite(id_regWrite), .id_ALUOp(id_ALUOp), .flush(flush), .stall_in(stall_in),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_rs1_data(ex_rs1_data),
    .ex_rs2_data(ex_rs2_data), .ex_imm(ex_imm), .ex_rs1(ex_rs1), .ex_rs2(ex_rs2),
    .ex_rd(ex_rd), .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_branch(ex_branch), .ex_memRead(ex_memRead), .ex_memToReg(ex_memToReg),
    .ex_memWrite(ex_memWrite), .ex_ALUSrc(ex_ALUSrc), .ex_regWrite(ex_regWrite),
    .ex_ALUOp(ex_ALUOp), .hazard_stall(hazard_stall), .bubble_count(bubble_count)
  );

  id_ex_stage #(.XLEN(32), .CNT_W(2)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_pc(id_pc),
    .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .id_funct3(id_funct3),
    .id_funct7b5(id_funct7b5), .id_branch(id_branch), .id_memRead(id_memRead),
    .id_memToReg(id_memToReg), .id_memWrite(id_memWrite), .id_ALUSrc(id_ALUSrc),
    .id_regWrite(id_regWrite), .id_ALUOp(id_ALUOp), .flush(flush), .stall_in(stall_in),
    .ex_valid(d2_valid), .ex_pc(d2_pc), .ex_rs1_data(d2_rs1_data),
    .ex_rs2_data(d2_rs2_data), .ex_imm(d2_imm), .ex_rs1(d2_rs1), .ex_rs2(d2_rs2),
    .ex_rd(d2_rd), .ex_funct3(d2_funct3), .ex_funct7b5(d2_funct7b5),
    .ex_branch(d2_branch), .ex_memRead(d2_memRead), .ex_memToReg(d2_memToReg),
    .ex_memWrite(d2_memWrite), .ex_ALUSrc(d2_ALUSrc), .ex_regWrite(d2_regWrite),
    .ex_ALUOp(d2_ALUOp), .hazard_stall(d2_hazard), .bubble_count(d2_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  stage_t m;
  int     mcnt = 0;
  logic   mvalid = 1'b0;

  function automatic logic exp_hazard();
    return !flush && id_in.v && m.v && m.mr && (m.rd != 5'd0) &&
           ((m.rd == id_in.rs1) || (m.rd == id_in.rs2));
  endfunction

  function automatic stage_t as_bubble(input stage_t s);
    stage_t b;
    b = s;
    b.v = 1'b0; b.br = 1'b0; b.mr = 1'b0; b.m2r = 1'b0;
    b.mw = 1'b0; b.as = 1'b0; b.rw = 1'b0; b.op = 2'b00;
    return b;
  endfunction

  // Model update: what EX must contain after each edge.
  always @(posedge clk) begin
    if (rst) begin
      m <= '0; mcnt <= 0; mvalid <= 1'b1;
    end else if (flush) begin
      m <= as_bubble(id_in);
    end else if (stall_in) begin
      m <= m;
    end else if (exp_hazard()) begin
      m <= as_bubble(id_in); mcnt <= mcnt + 1;
    end else begin
      m <= id_in;
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (mvalid) begin
      chk("ex_valid", 64'(dut_ex.v), 64'(m.v));
      chk("ctl", 64'({dut_ex.br, dut_ex.mr, dut_ex.m2r, dut_ex.mw, dut_ex.as, dut_ex.rw, dut_ex.op}),
                 64'({m.br, m.mr, m.m2r, m.mw, m.as, m.rw, m.op}));
      if (m.v) begin
        chk("ex_pc", 64'(dut_ex.pc), 64'(m.pc));
        chk("ex_rs1_data", 64'(dut_ex.r1d), 64'(m.r1d));
        chk("ex_rs2_data", 64'(dut_ex.r2d), 64'(m.r2d));
        chk("ex_imm", 64'(dut_ex.imm), 64'(m.imm));
        chk("ex_idx", 64'({dut_ex.rs1, dut_ex.rs2, dut_ex.rd}), 64'({m.rs1, m.rs2, m.rd}));
        chk("ex_funct", 64'({dut_ex.f3, dut_ex.f7}), 64'({m.f3, m.f7}));
      end
      chk("hazard_stall", 64'(hazard_stall), 64'(exp_hazard()));
      chk("bubble_count", 64'(bubble_count), 64'((mcnt > 65535) ? 65535 : mcnt));
      chk("d2_ctl", 64'({d2_valid, d2_memRead, d2_regWrite, d2_hazard}),
                    64'({m.v, m.mr, m.rw, exp_hazard()}));
      chk("d2_bubble_count", 64'(d2_count), 64'((mcnt > 3) ? 3 : mcnt));
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(); @(posedge clk); #1; endtask
  task automatic look(); @(negedge clk); #1; endtask

  function automatic stage_t r_type(input logic [4:0] rd, input logic [4:0] rs1,
                                    input logic [4:0] rs2);
    stage_t s;
    s = '0; s.v = 1'b1; s.pc = 32'h100 + 32'(rd); s.r1d = 32'h10; s.r2d = 32'h20;
    s.rd = rd; s.rs1 = rs1; s.rs2 = rs2; s.rw = 1'b1; s.op = 2'b10;
    return s;
  endfunction

  function automatic stage_t lw(input logic [4:0] rd, input logic [4:0] rs1);
    stage_t s;
    s = '0; s.v = 1'b1; s.pc = 32'h200; s.r1d = 32'h1000; s.imm = 32'h4;
    s.rd = rd; s.rs1 = rs1; s.f3 = 3'd2; s.mr = 1'b1; s.m2r = 1'b1;
    s.as = 1'b1; s.rw = 1'b1; s.op = 2'b00;
    return s;
  endfunction

  initial begin
    rst = 1'b1; flush = 1'b0; stall_in = 1'b0;
    id_in = {$urandom, $urandom, $urandom, $urandom, $urandom};
    id_in.v = 1'b1; id_in.mr = 1'b1;
    tick(); tick();
    look();
    $display("reset: ex_valid=%0d bubble_count=%0d", ex_valid, bubble_count);
    chk("reset_valid", 64'(ex_valid), 64'd0);
    chk("reset_out", 64'({ex_pc, ex_rd, ex_memRead, ex_regWrite, ex_ALUOp}), 64'd0);
    chk("reset_hazard", 64'(hazard_stall), 64'd0);
    chk("reset_count", 64'(bubble_count), 64'd0);

    // Pass-through
    rst = 1'b0;
    id_in = r_type(5'd5, 5'd1, 5'd2);
    tick(); look();
    $display("pass-through: ex_rd=%0d rs1_data=%0h", ex_rd, ex_rs1_data);
    chk("pt_valid", 64'(ex_valid), 64'd1);
    chk("pt_rd", 64'(ex_rd), 64'd5);
    chk("pt_rs1_data", 64'(ex_rs1_data), 64'h10);
    chk("pt_aluop", 64'(ex_ALUOp), 64'd2);
    chk("pt_regwrite", 64'(ex_regWrite), 64'd1);

    // Load-use
    id_in = lw(5'd7, 5'd2);
    tick(); look();
    id_in = r_type(5'd8, 5'd7, 5'd3);
    #1;
    $display("load-use: hazard_stall=%0d", hazard_stall);
    chk("lu_hazard", 64'(hazard_stall), 64'd1);
    tick(); look();
    $display("load-use bubble: ex_valid=%0d bubble_count=%0d", ex_valid, bubble_count);
    chk("lu_bubble_valid", 64'(ex_valid), 64'd0);
    chk("lu_bubble_ctl", 64'({ex_branch, ex_memRead, ex_memToReg, ex_memWrite,
                              ex_ALUSrc, ex_regWrite, ex_ALUOp}), 64'd0);
    chk("lu_count", 64'(bubble_count), 64'd1);
    chk("lu_hazard_drop", 64'(hazard_stall), 64'd0);
    tick(); look();
    $display("load-use resume: ex_valid=%0d ex_rs1=%0d", ex_valid, ex_rs1);
    chk("lu_resume_valid", 64'(ex_valid), 64'd1);
    chk("lu_resume_rs1", 64'(ex_rs1), 64'd7);

    // x0 exemption
    id_in = lw(5'd0, 5'd5);
    tick(); look();
    id_in = r_type(5'd9, 5'd0, 5'd0);
    #1;
    chk("x0_hazard", 64'(hazard_stall), 64'd0);
    tick(); look();
    $display("x0: ex_valid=%0d ex_rd=%0d bubble_count=%0d", ex_valid, ex_rd, bubble_count);
    chk("x0_valid", 64'(ex_valid), 64'd1);
    chk("x0_rd", 64'(ex_rd), 64'd9);
    chk("x0_count", 64'(bubble_count), 64'd1);

    // Flush beats stall
    id_in = '0; id_in.v = 1'b1; id_in.rs1 = 5'd2; id_in.rs2 = 5'd9; id_in.imm = 32'h8;
    id_in.f3 = 3'd2; id_in.mw = 1'b1; id_in.as = 1'b1;
    flush = 1'b1; stall_in = 1'b1;
    tick(); look();
    $display("flush+stall: ex_valid=%0d ex_memWrite=%0d", ex_valid, ex_memWrite);
    chk("fl_valid", 64'(ex_valid), 64'd0);
    chk("fl_memwrite", 64'(ex_memWrite), 64'd0);
    chk("fl_count", 64'(bubble_count), 64'd1);
    flush = 1'b0; stall_in = 1'b0;

    // Stall alone holds for 3 cycles
    id_in = r_type(5'd10, 5'd1, 5'd2);
    tick(); look();
    stall_in = 1'b1;
    id_in = r_type(5'd13, 5'd3, 5'd4);
    for (int k = 0; k < 3; k++) begin
      tick(); look();
      $display("stall %0d: ex_rd=%0d ex_valid=%0d", k, ex_rd, ex_valid);
      chk("hold_rd", 64'(ex_rd), 64'd10);
      chk("hold_pc", 64'(ex_pc), 64'h10a);
    end
    stall_in = 1'b0;
    tick(); look();
    $display("release: ex_rd=%0d", ex_rd);
    chk("release_rd", 64'(ex_rd), 64'd13);

    // Hazard while held: freeze reported, no bubble counted until release
    id_in = lw(5'd4, 5'd1);
    tick(); look();
    id_in = r_type(5'd11, 5'd1, 5'd4);
    stall_in = 1'b1;
    #1;
    chk("hs_hazard", 64'(hazard_stall), 64'd1);
    tick(); look();
    chk("hs_count_held", 64'(bubble_count), 64'd1);
    chk("hs_rd_held", 64'(ex_rd), 64'd4);
    stall_in = 1'b0;
    tick(); look();
    $display("hazard after hold: ex_valid=%0d bubble_count=%0d", ex_valid, bubble_count);
    chk("hs_bubble", 64'(ex_valid), 64'd0);
    chk("hs_count", 64'(bubble_count), 64'd2);
    tick(); look();
    chk("hs_resume_rd", 64'(ex_rd), 64'd11);

    // Saturation on the 2-bit counter
    rst = 1'b1;
    tick(); look();
    rst = 1'b0;
    chk("sat_reset", 64'(d2_count), 64'd0);
    for (int k = 1; k <= 5; k++) begin
      id_in = lw(5'd7, 5'd1);
      tick();
      id_in = r_type(5'd8, 5'd7, 5'd2);
      tick(); look();
      $display("saturation %0d: count16=%0d count2=%0d", k, bubble_count, d2_count);
      chk("sat_count2", 64'(d2_count), 64'((k > 3) ? 3 : k));
      chk("sat_count16", 64'(bubble_count), 64'(k));
    end

    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
